// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// rst_seq_pkg : state encoding and counter sizing shared by rst_seq_ctrl
// Revision    : 1.0
// ============================================================================
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_SYNC = 3'd0,
    ST_HOLD = 3'd1,
    ST_REL  = 3'd2,
    ST_RUN  = 3'd3,
    ST_SWA  = 3'd4
  } seq_state_e;

  // Bits needed to count 0..max_val-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rst_sync.sv
`default_nettype none
// ============================================================================
// rst_sync : async-assert / sync-deassert reset synchronizer
// Revision : 1.0
// ============================================================================
module rst_sync #(
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic clk_i,
  input  logic arst_n_i,
  output logic rst_n_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rst_n_o = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// rst_seq_ctrl : staged reset sequencer with software re-sequence; the
//                watchdog is built only when RST_SEQ_WDOG_EN is defined.
// Revision     : 1.0
// ============================================================================
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned STAGES         = 4,
  parameter int unsigned SYNC_STAGES    = 3,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned SW_HOLD_CYCLES = 32,
  parameter int unsigned WDOG_CYCLES    = 50_000_000
) (
  input  logic              sys_clk_i,
  input  logic              sys_arst_n_i,
  input  logic              sw_rst_req_i,
  input  logic              wdog_kick_i,
  output logic [STAGES-1:0] rst_n_o,
  output logic              seq_done_o,
  output logic              busy_o,
  output logic              wdog_trip_o
);

  localparam int unsigned CNT_W = cnt_width(max2(GAP_CYCLES, SW_HOLD_CYCLES));
  localparam int unsigned IDX_W = cnt_width(STAGES);

  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SW_HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(STAGES - 1);

  logic              sync_rst_n;
  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [STAGES-1:0] rst_n_q, rst_n_d;
  logic              seq_done_q, seq_done_d;
  logic              busy_q, busy_d;
  logic              wdog_fire;
  logic              seq_req;

  rst_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rst_sync (
    .clk_i    (sys_clk_i),
    .arst_n_i (sys_arst_n_i),
    .rst_n_o  (sync_rst_n)
  );

`ifdef RST_SEQ_WDOG_EN
  localparam int unsigned     WD_W    = cnt_width(WDOG_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            trip_q, trip_d;

  // A kick landing on the terminal count suppresses the trip.
  assign wdog_fire = (state_q == ST_RUN) && !wdog_kick_i && (wd_cnt_q == WD_LAST);

  always_comb begin
    wd_cnt_d = '0;
    trip_d   = trip_q | wdog_fire;
    if ((state_q == ST_RUN) && (state_d == ST_RUN) && !wdog_kick_i) begin
      wd_cnt_d = (wd_cnt_q == WD_LAST) ? wd_cnt_q : wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_arst_n_i) begin
    if (!sys_arst_n_i) begin
      wd_cnt_q <= '0;
      trip_q   <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      trip_q   <= trip_d;
    end
  end

  assign wdog_trip_o = trip_q;
`else
  logic unused_cfg;
  assign unused_cfg  = wdog_kick_i ^ (WDOG_CYCLES == 0);
  assign wdog_fire   = 1'b0;
  assign wdog_trip_o = 1'b0;
`endif

  assign seq_req = sw_rst_req_i || wdog_fire;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;

    case (state_q)
      ST_SYNC: begin
        if (sync_rst_n) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      // HOLD covers the first gap, REL every later one; both release idx_q.
      ST_HOLD, ST_REL: begin
        if (cnt_q == GAP_LAST) begin
          rst_n_d[idx_q] = 1'b1;
          cnt_d          = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_REL;
            idx_d   = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
      end
      ST_SWA: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_SYNC;
        cnt_d   = '0;
        idx_d   = '0;
        rst_n_d = '0;
      end
    endcase

    if (seq_req && (state_q != ST_SYNC)) begin
      state_d = ST_SWA;
      cnt_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
    end
  end

  // Done is flagged only after a full cycle in RUN, one edge after the last release.
  always_comb begin
    seq_done_d = (state_q == ST_RUN) && (state_d == ST_RUN);
    busy_d     = !seq_done_d;
  end

  // The FSM uses the raw reset: held in SYNC with zero counters its next state
  // equals its reset state, so deassert timing cannot disturb it.
  always_ff @(posedge sys_clk_i or negedge sys_arst_n_i) begin
    if (!sys_arst_n_i) begin
      state_q    <= ST_SYNC;
      cnt_q      <= '0;
      idx_q      <= '0;
      rst_n_q    <= '0;
      seq_done_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rst_n_q    <= rst_n_d;
      seq_done_q <= seq_done_d;
      busy_q     <= busy_d;
    end
  end

  assign rst_n_o    = rst_n_q;
  assign seq_done_o = seq_done_q;
  assign busy_o     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_rst_seq_ctrl : bench for rst_seq_ctrl against a release-time model
// Revision        : 1.0
// ============================================================================
module tb_rst_seq_ctrl;

  localparam int STAGES      = 4;
  localparam int SYNC_STAGES = 3;
  localparam int GAP         = 16;
  localparam int SW_HOLD     = 32;
  localparam int WDOG        = 100;
`ifdef RST_SEQ_WDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic              clk    = 1'b0;
  logic              arst_n = 1'b0;
  logic              sw_req = 1'b0;
  logic              kick   = 1'b0;
  logic [STAGES-1:0] rst_n;
  logic              seq_done;
  logic              busy;
  logic              trip;

  always #5 clk = ~clk;

  rst_seq_ctrl #(
    .STAGES         (STAGES),
    .SYNC_STAGES    (SYNC_STAGES),
    .GAP_CYCLES     (GAP),
    .SW_HOLD_CYCLES (SW_HOLD),
    .WDOG_CYCLES    (WDOG)
  ) dut (
    .sys_clk_i    (clk),
    .sys_arst_n_i (arst_n),
    .sw_rst_req_i (sw_req),
    .wdog_kick_i  (kick),
    .rst_n_o      (rst_n),
    .seq_done_o   (seq_done),
    .busy_o       (busy),
    .wdog_trip_o  (trip)
  );

  int cyc;
  int n_checks;
  int n_pass;
  int rel_base;   // edge where the first release gap starts
  int last_clr;   // last watchdog-clearing kick edge
  bit trip_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
  endtask

  // Bit k is released GAP*(k+1) edges after rel_base; done one edge after the last.
  function automatic logic [STAGES-1:0] exp_rst(input int c);
    logic [STAGES-1:0] r;
    r = '0;
    for (int k = 0; k < STAGES; k++) r[k] = (c >= rel_base + GAP * (k + 1));
    return r;
  endfunction

  function automatic logic exp_done(input int c);
    return (c >= rel_base + GAP * STAGES + 1);
  endfunction

  task automatic model_reset;
    rel_base = SYNC_STAGES;
    last_clr = 0;
    trip_m   = 1'b0;
    cyc      = -1;
  endtask

  // Inputs s/k are captured at edge e.
  task automatic model_apply(input int e, input logic s, input logic k);
    int run_entry;
    int wd_base;
    bit fire;
    run_entry = rel_base + GAP * STAGES;
    wd_base   = (last_clr > run_entry) ? last_clr : run_entry;
    fire      = WD_EN && (e > run_entry) && !k && (e == wd_base + WDOG);
    if (WD_EN && (e > run_entry) && k) last_clr = e;
    if (fire) trip_m = 1'b1;
    if ((s || fire) && (e > SYNC_STAGES)) begin
      rel_base = e + SW_HOLD;
      last_clr = 0;
    end
  endtask

  task automatic step(input logic s, input logic k);
    @(posedge clk);
    cyc++;
    #1;
    sw_req = s;
    kick   = k;
    @(negedge clk);
    chk("rst_n_o",     32'(rst_n),    32'(exp_rst(cyc)));
    chk("seq_done_o",  32'(seq_done), 32'(exp_done(cyc)));
    chk("busy_o",      32'(busy),     32'(!exp_done(cyc)));
    chk("wdog_trip_o", 32'(trip),     32'(trip_m));
    model_apply(cyc + 1, s, k);
  endtask

  task automatic async_reset_check;
    arst_n = 1'b0;
    #1;
    chk("async_rst_n",    32'(rst_n),    0);
    chk("async_seq_done", 32'(seq_done), 0);
    chk("async_busy",     32'(busy),     1);
    chk("async_trip",     32'(trip),     0);
    sw_req = 1'b0;
    kick   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("inrst_rst_n", 32'(rst_n), 0);
    chk("inrst_busy",  32'(busy),  1);
    arst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_pass   = 0;
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("por_rst_n",    32'(rst_n),    0);
    chk("por_seq_done", 32'(seq_done), 0);
    chk("por_busy",     32'(busy),     1);
    chk("por_trip",     32'(trip),     0);
    arst_n = 1'b1;

    // Power-up release times.
    while (cyc < 80) begin
      step(1'b0, 1'b0);
      if (cyc == 18) chk("pu_c18", 32'(rst_n), 0);
      if (cyc == 19) chk("pu_c19", 32'(rst_n), 1);
      if (cyc == 35) chk("pu_c35", 32'(rst_n), 3);
      if (cyc == 51) chk("pu_c51", 32'(rst_n), 7);
      if (cyc == 67) begin
        chk("pu_c67", 32'(rst_n), 15);
        chk("pu_done_c67", 32'(seq_done), 0);
      end
      if (cyc == 68) begin
        chk("pu_done_c68", 32'(seq_done), 1);
        chk("pu_busy_c68", 32'(busy), 0);
      end
    end

    // Software reset from RUN at T=100.
    while (cyc < 210) begin
      n = cyc + 1;
      step(n == 100, 1'b0);
      if (cyc == 101) chk("sw_c101", 32'(rst_n), 0);
      if (cyc == 148) chk("sw_c148", 32'(rst_n), 0);
      if (cyc == 149) chk("sw_c149", 32'(rst_n), 1);
      if (cyc == 197) chk("sw_c197", 32'(rst_n), 15);
      if (cyc == 198) chk("sw_done_c198", 32'(seq_done), 1);
    end

    async_reset_check();

    // Ignored request in SYNC, mid-sequence request, extension in SWA,
    // then watchdog starvation, periodic kicks and a kick on terminal count.
    while (cyc < 905) begin
      n = cyc + 1;
      step((n == 1) || (n == 40) || (n == 95) || (n == 100),
           ((n >= 400) && (n <= 800) && (n % 50 == 0)) || (n == 900));
      if (cyc == 19) chk("mid_c19", 32'(rst_n), 1);
      if (cyc == 41) chk("mid_c41", 32'(rst_n), 0);
      if (cyc == 88) chk("mid_c88", 32'(rst_n), 0);
      if (cyc == 89) chk("mid_c89", 32'(rst_n), 1);
      if (cyc == 148) chk("ext_c148", 32'(rst_n), 0);
      if (cyc == 149) chk("ext_c149", 32'(rst_n), 1);
      if (cyc == 198) chk("ext_done_c198", 32'(seq_done), 1);
      if (cyc == 297) begin
`ifdef RST_SEQ_WDOG_EN
        chk("wd_trip_c297", 32'(trip), 1);
        chk("wd_rst_c297",  32'(rst_n), 0);
`else
        chk("wd_trip_c297", 32'(trip), 0);
        chk("wd_rst_c297",  32'(rst_n), 15);
`endif
      end
      if (cyc == 394) chk("wd_done_c394", 32'(seq_done), 1);
      if (cyc == 801) chk("kick_trip_c801", 32'(trip), WD_EN ? 1 : 0);
      if (cyc == 901) begin
        chk("kick_tc_done", 32'(seq_done), 1);
        chk("kick_tc_rst",  32'(rst_n), 15);
      end
      if (cyc == 902) chk("kick_tc_busy", 32'(busy), 0);
    end

    async_reset_check();

    while (cyc < 60) begin
      step(1'b0, 1'b0);
      if (cyc == 35) chk("pu3_c35", 32'(rst_n), 3);
    end

    async_reset_check();

    // Randomized requests and kicks.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
